// File: rtl/pcle_pkg.sv
// Shared types and constants for the loadable up-counter sequencer.
package pcle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pcle_state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/pcle_cnt.sv
// Combinational next-value cell for the loadable up-counter.
// Load wins over increment; carry flags an enabled tick at the all-ones value.
module pcle_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt,
    output logic             carry
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Select load value, incremented value (wraps modulo 2^WIDTH) or hold.
    always_comb begin
        nxt   = cur;
        carry = enable & (cur == {WIDTH{1'b1}});
        if (load) begin
            nxt = load_val;
        end else if (enable) begin
            nxt = cur + ONE;
        end
    end

endmodule

// File: rtl/pcle_seq.sv
// Sequencer for the loadable up-counter: holds reload value and mode,
// loads on start, gates ticks, and reports terminal count (periodic or one-shot).
module pcle_seq
    import pcle_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TC_CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [WIDTH-1:0]    cfg_reload,
    input  logic                cfg_periodic,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                tick,
    output logic [WIDTH-1:0]    count,
    output logic                tc,
    output logic                busy,
    output logic                done,
    output logic [TC_CNT_W-1:0] tc_events
);

    localparam logic [TC_CNT_W-1:0] EV_ONE = {{(TC_CNT_W-1){1'b0}}, 1'b1};

    pcle_state_e         state_q,  state_d;
    logic [WIDTH-1:0]    count_q,  count_d;
    logic [WIDTH-1:0]    reload_q, reload_d;
    logic                mode_q,   mode_d;
    logic                tc_q,     tc_d;
    logic [TC_CNT_W-1:0] ev_q,     ev_d;

    logic                cfg_fire;
    logic                start_go;
    logic [WIDTH-1:0]    start_val;
    logic                start_mode;
    logic                cnt_load;
    logic [WIDTH-1:0]    cnt_load_val;
    logic                cnt_en;
    logic [WIDTH-1:0]    cnt_nxt;
    logic                cnt_carry;

    pcle_cnt #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .enable   (cnt_en),
        .cur      (count_q),
        .nxt      (cnt_nxt),
        .carry    (cnt_carry)
    );

    // All state flops; asynchronous reset returns everything to idle defaults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= MODE_ONESHOT;
            tc_q     <= 1'b0;
            ev_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
            ev_q     <= ev_d;
        end
    end

    // Next-state logic; priority is clear > stop > start > tick.
    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        ev_d     = ev_q;

        // Config is blocked in RUN and swallowed by clear.
        cfg_fire   = cfg_valid & (state_q != RUN) & ~clear;
        // Start and stop act in disjoint states, so stop need not gate start.
        start_go   = start & (state_q != RUN) & ~clear;
        start_val  = cfg_fire ? cfg_reload   : reload_q;
        start_mode = cfg_fire ? cfg_periodic : mode_q;

        cnt_en       = (state_q == RUN) & tick & ~stop & ~clear;
        // Start and a terminal carry are mutually exclusive (different states).
        cnt_load     = start_go | (cnt_carry & (mode_q == MODE_PERIODIC));
        cnt_load_val = start_go ? start_val : reload_q;

        count_d = clear ? '0 : cnt_nxt;
        tc_d    = cnt_carry;

        if (cfg_fire) begin
            reload_d = cfg_reload;
            mode_d   = cfg_periodic;
        end
        if (start_go) begin
            mode_d = start_mode;
        end

        if (clear || start_go) begin
            ev_d = '0;
        end else if (cnt_carry && (ev_q != {TC_CNT_W{1'b1}})) begin
            ev_d = ev_q + EV_ONE;
        end

        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (cnt_carry && (mode_q == MODE_ONESHOT)) begin
                        state_d = DONE;
                    end
                end
                IDLE, DONE: begin
                    if (start_go) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign count     = count_q;
    assign tc        = tc_q;
    assign tc_events = ev_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign cfg_ready = (state_q != RUN);

endmodule

// File: tb/tb_pcle_seq.sv
// Self-checking bench for pcle_seq: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a behavioural model.
module tb_pcle_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid, cfg_periodic, start, stop, clear, tick;
    logic [7:0] cfg_reload;
    logic       cfg_ready, tc, busy, done;
    logic [7:0] count;
    logic [3:0] tc_events;

    int errors = 0;
    int checks = 0;

    // Behavioural model: 0 idle, 1 running, 2 finished
    int m_phase, m_count, m_tc, m_ev, m_reload, m_per;

    always #5 clk = ~clk;

    pcle_seq #(.WIDTH(8), .TC_CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_reload   (cfg_reload),
        .cfg_periodic (cfg_periodic),
        .start        (start),
        .stop         (stop),
        .clear        (clear),
        .tick         (tick),
        .count        (count),
        .tc           (tc),
        .busy         (busy),
        .done         (done),
        .tc_events    (tc_events)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_count = 0; m_tc = 0; m_ev = 0; m_reload = 0; m_per = 0;
    endtask

    task automatic check_all(input string where);
        check({where, ".count"},     count,     m_count);
        check({where, ".tc"},        tc,        m_tc);
        check({where, ".busy"},      busy,      (m_phase == 1) ? 1 : 0);
        check({where, ".done"},      done,      (m_phase == 2) ? 1 : 0);
        check({where, ".cfg_ready"}, cfg_ready, (m_phase != 1) ? 1 : 0);
        check({where, ".tc_events"}, tc_events, m_ev);
    endtask

    // Advance the model by one clock given the inputs of that cycle.
    task automatic model_step(input int cv, input int cr, input int cp,
                              input int st, input int sp, input int cl, input int tk);
        int accepting;
        accepting = (m_phase != 1);
        m_tc = 0;
        if (cl) begin
            m_count = 0; m_phase = 0; m_ev = 0;
        end else begin
            if (cv && accepting) begin
                m_reload = cr; m_per = cp;
            end
            if (m_phase == 1) begin
                if (sp) begin
                    m_phase = 0;
                end else if (tk) begin
                    if (m_count == 255) begin
                        m_tc = 1;
                        if (m_ev < 15) m_ev = m_ev + 1;
                        if (m_per) m_count = m_reload;
                        else begin m_count = 0; m_phase = 2; end
                    end else begin
                        m_count = m_count + 1;
                    end
                end
            end else if (st) begin
                m_count = m_reload; m_phase = 1; m_ev = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic cycle(input string where, input int cv, input int cr, input int cp,
                         input int st, input int sp, input int cl, input int tk);
        cfg_valid = cv[0]; cfg_reload = cr[7:0]; cfg_periodic = cp[0];
        start = st[0]; stop = sp[0]; clear = cl[0]; tick = tk[0];
        model_step(cv, cr & 255, cp & 1, st, sp, cl, tk);
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    initial begin
        int tcs;
        rst_n = 1'b0;
        cfg_valid = 0; cfg_reload = 0; cfg_periodic = 0;
        start = 0; stop = 0; clear = 0; tick = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // One-shot from FD: three ticks reach terminal count and DONE
        cycle("os_start", 1, 'hFD, 0, 1, 0, 0, 0);
        check("os_load", count, 'hFD);
        cycle("os_t1", 0, 0, 0, 0, 0, 0, 1);
        cycle("os_t2", 0, 0, 0, 0, 0, 0, 1);
        check("os_ff", count, 'hFF);
        cycle("os_t3", 0, 0, 0, 0, 0, 0, 1);
        check("os_wrap", count, 0);
        check("os_tc", tc, 1);
        check("os_done", done, 1);
        check("os_ev", tc_events, 1);
        cycle("os_idle", 0, 0, 0, 0, 0, 0, 1);
        check("os_tc_once", tc, 0);

        // Same-cycle config + start from DONE uses the new reload value
        cycle("byp", 1, 'h10, 1, 1, 0, 0, 0);
        check("byp_count", count, 'h10);
        check("byp_busy", busy, 1);
        cycle("byp_stop", 0, 0, 0, 0, 1, 0, 0);

        // Periodic from FE: six ticks give three tc pulses
        cycle("per_start", 1, 'hFE, 1, 1, 0, 0, 0);
        tcs = 0;
        for (int i = 0; i < 6; i++) begin
            cycle("per_tick", 0, 0, 0, 0, 0, 0, 1);
            tcs += tc;
        end
        check("per_tc_pulses", tcs, 3);
        check("per_busy", busy, 1);
        check("per_ev", tc_events, 3);

        // Config during RUN is refused; stop beats a terminal tick
        cycle("run_cfg", 1, 'h55, 0, 0, 0, 0, 0);
        check("run_cfg_ready", cfg_ready, 0);
        cycle("to_ff", 0, 0, 0, 0, 0, 0, 1);
        check("to_ff_count", count, 'hFF);
        cycle("stop_tick", 0, 0, 0, 0, 1, 0, 1);
        check("stop_count", count, 'hFF);
        check("stop_tc", tc, 0);
        check("stop_busy", busy, 0);
        cycle("restart", 0, 0, 0, 1, 0, 0, 0);
        check("reload_kept", count, 'hFE);

        // Clear overrides start and tick; reload survives
        cycle("clr", 1, 'h77, 0, 1, 0, 1, 1);
        check("clr_count", count, 0);
        check("clr_busy", busy, 0);
        cycle("clr_restart", 0, 0, 0, 1, 0, 0, 0);
        check("clr_reload", count, 'hFE);

        // Saturation: reload = max, periodic, 20 ticks
        cycle("sat_stop", 0, 0, 0, 0, 1, 0, 0);
        cycle("sat_start", 1, 'hFF, 1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle("sat_tick", 0, 0, 0, 0, 0, 0, 1);
        check("sat_ev", tc_events, 15);
        check("sat_count", count, 'hFF);

        // Randomized traffic; reload values skewed near max to hit terminal count
        for (int i = 0; i < 400; i++) begin
            int r;
            r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(240, 255));
            cycle("rnd",
                  ($urandom_range(0, 3) == 0) ? 1 : 0, r, int'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  ($urandom_range(0, 31) == 0) ? 1 : 0,
                  ($urandom_range(0, 63) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) != 0) ? 1 : 0);
        end

        // Asynchronous reset in the middle of RUN
        cycle("ar_start", 1, 'hF0, 1, 1, 0, 0, 0);
        cycle("ar_tick", 0, 0, 0, 0, 0, 0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("ar_post", 0, 0, 0, 1, 0, 0, 0);
        check("ar_reload_zero", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
